alu_exerciser: RTL and testbench

//  Self-checking initiator for the 4-bit registered ALU (op/a/b in, result/out registered on clk).
//  On start it walks every {op,a,b} vector, drives the ALU operand port, waits the ALU latency,

---
 rtl/alu_ex_pkg.sv | 28 ++
 rtl/alu_ref_model.sv | 45 ++++
 rtl/alu_exerciser.sv | 141 ++++++++++++++
 tb/tb_alu_exerciser.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ex_pkg.sv
// Shared encodings for the ALU exerciser: op codes, FSM states and vector index layout.
package alu_ex_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LT  = 3'b110,
        OP_EQ  = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        FINISH
    } state_e;

    localparam int unsigned IDX_W      = 11;
    localparam int unsigned IDX_OP_LSB = 8;
    localparam int unsigned IDX_A_LSB  = 4;
    localparam int unsigned IDX_B_LSB  = 0;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU; chk_c flags ops whose carry is meaningful.
module alu_ref_model
    import alu_ex_pkg::*;
(
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] exp_r,
    output logic       exp_c,
    output logic       chk_c
);

    logic [3:0] neg_b;
    logic [4:0] sum;
    logic [4:0] dif;

    // Subtract is add of two's complement, so b=0 yields no carry.
    assign neg_b = ~b + 4'd1;
    assign sum   = {1'b0, a} + {1'b0, b};
    assign dif   = {1'b0, a} + {1'b0, neg_b};

    always_comb begin
        exp_r = 4'd0;
        exp_c = 1'b0;
        chk_c = 1'b0;
        unique case (op)
            OP_ADD: begin
                {exp_c, exp_r} = sum;
                chk_c          = 1'b1;
            end
            OP_SUB: begin
                {exp_c, exp_r} = dif;
                chk_c          = 1'b1;
            end
            OP_NOT: exp_r = ~a;
            OP_AND: exp_r = a & b;
            OP_OR:  exp_r = a | b;
            OP_XOR: exp_r = a ^ b;
            OP_LT:  exp_r = {3'b000, $signed(a) < $signed(b)};
            OP_EQ:  exp_r = {3'b000, a == b};
            default: exp_r = 4'd0;
        endcase
    end

endmodule

// File: rtl/alu_exerciser.sv
// Walks every {op,a,b} vector through an external registered ALU and scores the results
// against the golden model.
module alu_exerciser
    import alu_ex_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned NUM_VEC = 2048,
    parameter int unsigned CNT_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [2:0]       alu_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_result,
    input  logic             alu_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [IDX_W-1:0] first_err
);

    localparam int unsigned      LAT_W     = (ALU_LAT > 2) ? $clog2(ALU_LAT - 1) : 1;
    localparam logic [LAT_W-1:0] WAIT_LAST = LAT_W'((ALU_LAT > 1) ? ALU_LAT - 2 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_next;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [2:0]       op_q, op_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] pass_q, pass_d, err_q, err_d;
    logic [IDX_W-1:0] first_err_q, first_err_d;

    logic [3:0] exp_r;
    logic       exp_c;
    logic       chk_c;
    logic       match;

    alu_ref_model u_ref (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .exp_r (exp_r),
        .exp_c (exp_c),
        .chk_c (chk_c)
    );

    assign idx_next = idx_q + 1'b1;
    assign match    = (alu_result == exp_r) && (!chk_c || (alu_out == exp_c));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        pass_d      = pass_q;
        err_d       = err_q;
        first_err_d = first_err_q;
        unique case (state_q)
            IDLE, FINISH: begin
                if (start) begin
                    state_d     = ISSUE;
                    idx_d       = '0;
                    op_d        = 3'd0;
                    a_d         = 4'd0;
                    b_d         = 4'd0;
                    pass_d      = '0;
                    err_d       = '0;
                    first_err_d = '0;
                end
            end
            ISSUE: begin
                lat_d = '0;
                if (ALU_LAT > 1) state_d = WAIT;
                else             state_d = CHECK;
            end
            WAIT: begin
                if (lat_q == WAIT_LAST) state_d = CHECK;
                else                    lat_d   = lat_q + 1'b1;
            end
            CHECK: begin
                if (match) begin
                    if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
                end else begin
                    if (err_q != CNT_MAX) err_d = err_q + 1'b1;
                    if (err_q == '0) first_err_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end else begin
                    state_d = ISSUE;
                    idx_d   = idx_next;
                    op_d    = idx_next[IDX_OP_LSB +: 3];
                    a_d     = idx_next[IDX_A_LSB +: 4];
                    b_d     = idx_next[IDX_B_LSB +: 4];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            lat_q       <= '0;
            op_q        <= 3'd0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            pass_q      <= '0;
            err_q       <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign busy      = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CHECK);
    assign done      = (state_q == FINISH);
    assign pass_cnt  = pass_q;
    assign err_cnt   = err_q;
    assign first_err = first_err_q;

endmodule

// File: tb/tb_alu_exerciser.sv
// Bench for alu_exerciser: three exerciser builds each paired with a behavioural ALU, a run
// scoreboard, and a table of golden-model corner vectors.
module tb_alu_exerciser;
    import alu_ex_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic fault = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    // LAT=1 build, full run
    logic        start1 = 1'b0;
    logic [2:0]  op1;
    logic [3:0]  a1, b1, r1;
    logic        c1, busy1, done1;
    logic [11:0] pass1, err1;
    logic [10:0] fe1;
    // LAT=3 build
    logic        start3 = 1'b0;
    logic [2:0]  op3;
    logic [3:0]  a3, b3, r3;
    logic        c3, busy3, done3;
    logic [11:0] pass3, err3;
    logic [10:0] fe3;
    // short run with 4-bit counters to reach saturation
    logic        starts = 1'b0;
    logic [2:0]  ops;
    logic [3:0]  as_, bs, rs;
    logic        cs, busys, dones;
    logic [3:0]  passs, errs;
    logic [10:0] fes;

    alu_exerciser #(.ALU_LAT(1), .NUM_VEC(2048), .CNT_W(12)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .alu_op(op1), .alu_a(a1), .alu_b(b1),
        .alu_result(r1), .alu_out(c1), .busy(busy1), .done(done1), .pass_cnt(pass1),
        .err_cnt(err1), .first_err(fe1)
    );
    alu_exerciser #(.ALU_LAT(3), .NUM_VEC(2048), .CNT_W(12)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .alu_op(op3), .alu_a(a3), .alu_b(b3),
        .alu_result(r3), .alu_out(c3), .busy(busy3), .done(done3), .pass_cnt(pass3),
        .err_cnt(err3), .first_err(fe3)
    );
    alu_exerciser #(.ALU_LAT(1), .NUM_VEC(64), .CNT_W(4)) duts (
        .clk(clk), .rst(rst), .start(starts), .alu_op(ops), .alu_a(as_), .alu_b(bs),
        .alu_result(rs), .alu_out(cs), .busy(busys), .done(dones), .pass_cnt(passs),
        .err_cnt(errs), .first_err(fes)
    );

    // Behavioural ALU: returns {carry, result}; carry is held for non-arithmetic ops.
    function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic cin,
                                         input logic flt);
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        c = cin;
        r = 4'd0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; c = s[4]; r = s[3:0]; end
            3'd1: begin r = a - b; c = (b != 4'd0) && (a >= b); end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = {3'b000, (a[3] != b[3]) ? a[3] : (a < b)};
            default: r = {3'b000, a == b};
        endcase
        if (flt && op == 3'd3) r[0] = 1'b0;
        return {c, r};
    endfunction

    logic [4:0] alu1_q = 5'd0;
    logic [4:0] p1 = 5'd0, p2 = 5'd0, p3 = 5'd0;
    logic [4:0] alus_q = 5'd0;
    always @(posedge clk) begin
        alu1_q <= alu_f(op1, a1, b1, alu1_q[4], fault);
        p1     <= alu_f(op3, a3, b3, p1[4], 1'b0);
        p2     <= p1;
        p3     <= p2;
        alus_q <= alu_f(ops, as_, bs, alus_q[4], 1'b0);
    end
    assign {c1, r1} = alu1_q;
    assign {c3, r3} = p3;
    assign {cs, rs} = alus_q;

    // Standalone golden model for the corner-vector table
    logic [2:0] m_op;
    logic [3:0] m_a, m_b, m_r;
    logic       m_c, m_k;
    alu_ref_model u_model (
        .op(m_op), .a(m_a), .b(m_b), .exp_r(m_r), .exp_c(m_c), .chk_c(m_k)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [11:0] pass;
        logic [11:0] err;
        logic [10:0] fe;
        logic [2:0]  op;
        logic [3:0]  a;
        logic [3:0]  b;
    } obs_t;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        logic       c;
        logic       k;
    } vec_t;

    typedef struct {
        int          inst;
        logic        flt;
        logic        pulse;
        int          cycles;
        int          pass;
        int          err;
        logic [10:0] fe;
    } run_t;

    run_t sb[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic obs_t get_obs(input int inst);
        obs_t o;
        case (inst)
            1: o = '{busy1, done1, pass1, err1, fe1, op1, a1, b1};
            3: o = '{busy3, done3, pass3, err3, fe3, op3, a3, b3};
            default: o = '{busys, dones, {8'd0, passs}, {8'd0, errs}, fes, ops, as_, bs};
        endcase
        return o;
    endfunction

    task automatic set_start(input int inst, input logic v);
        case (inst)
            1: start1 = v;
            3: start3 = v;
            default: starts = v;
        endcase
    endtask

    task automatic do_run(input run_t rr);
        obs_t        o;
        run_t        e;
        int          cnt;
        int          walk_bad;
        int          lat;
        logic [10:0] ei;
        lat   = (rr.inst == 3) ? 3 : 1;
        fault = rr.flt;
        @(negedge clk);
        set_start(rr.inst, 1'b1);
        sb.push_back(rr);
        @(negedge clk);
        set_start(rr.inst, 1'b0);
        o = get_obs(rr.inst);
        check($sformatf("busy after start inst%0d", rr.inst), 64'(o.busy), 64'd1);
        cnt      = 0;
        walk_bad = 0;
        while (!o.done && cnt < rr.cycles + 200) begin
            if (o.busy) begin
                ei = 11'(cnt / (lat + 1));
                if ({o.op, o.a, o.b} != ei) walk_bad++;
            end
            @(negedge clk);
            cnt++;
            set_start(rr.inst, rr.pulse && ((cnt % 97) == 3));
            o = get_obs(rr.inst);
        end
        set_start(rr.inst, 1'b0);
        if (sb.size() == 0) begin
            check("scoreboard empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("run cycles inst%0d", e.inst), 64'(cnt), 64'(e.cycles));
            check($sformatf("done inst%0d", e.inst), 64'({o.done, o.busy}), 64'b10);
            check($sformatf("pass_cnt inst%0d", e.inst), 64'(o.pass), 64'(e.pass));
            check($sformatf("err_cnt inst%0d", e.inst), 64'(o.err), 64'(e.err));
            check($sformatf("first_err inst%0d", e.inst), 64'(o.fe), 64'(e.fe));
            check($sformatf("operand walk inst%0d", e.inst), 64'(walk_bad), 64'd0);
        end
    endtask

    vec_t vt[13];
    run_t rt[5];

    initial begin
        obs_t o;
        vt[0]  = '{3'd1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        vt[1]  = '{3'd1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b1};
        vt[2]  = '{3'd1, 4'h5, 4'h3, 4'h2, 1'b1, 1'b1};
        vt[3]  = '{3'd6, 4'h8, 4'h7, 4'h1, 1'b0, 1'b0};
        vt[4]  = '{3'd6, 4'h7, 4'h8, 4'h0, 1'b0, 1'b0};
        vt[5]  = '{3'd0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1};
        vt[6]  = '{3'd0, 4'h7, 4'h8, 4'hF, 1'b0, 1'b1};
        vt[7]  = '{3'd2, 4'h5, 4'h0, 4'hA, 1'b0, 1'b0};
        vt[8]  = '{3'd3, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0};
        vt[9]  = '{3'd4, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0};
        vt[10] = '{3'd5, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0};
        vt[11] = '{3'd7, 4'h9, 4'h9, 4'h1, 1'b0, 1'b0};
        vt[12] = '{3'd7, 4'h9, 4'h8, 4'h0, 1'b0, 1'b0};

        // a&b odd needs a[0]&b[0]: 8*8 = 64 mismatches, first at op3 a1 b1
        rt[0] = '{1, 1'b0, 1'b0, 4096, 2048, 0,  11'h000};
        rt[1] = '{1, 1'b1, 1'b0, 4096, 1984, 64, 11'h311};
        rt[2] = '{1, 1'b0, 1'b1, 4096, 2048, 0,  11'h000};
        rt[3] = '{3, 1'b0, 1'b0, 8192, 2048, 0,  11'h000};
        rt[4] = '{0, 1'b0, 1'b0, 128,  15,   0,  11'h000};

        // Reset with start held high: start must be ignored
        start1 = 1'b1;
        start3 = 1'b1;
        starts = 1'b1;
        repeat (2) @(negedge clk);
        check("reset state inst1", 64'(get_obs(1)), 64'd0);
        check("reset state inst3", 64'(get_obs(3)), 64'd0);
        check("reset state small", 64'(get_obs(0)), 64'd0);
        rst    = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        starts = 1'b0;
        @(negedge clk);
        check("idle after reset", 64'({busy1, busy3, busys, done1, done3, dones}), 64'd0);

        for (int i = 0; i < 13; i++) begin
            m_op = vt[i].op;
            m_a  = vt[i].a;
            m_b  = vt[i].b;
            #1;
            check($sformatf("model r vec%0d", i), 64'({m_r, m_k}), 64'({vt[i].r, vt[i].k}));
            if (vt[i].k) check($sformatf("model c vec%0d", i), 64'(m_c), 64'(vt[i].c));
        end

        for (int i = 0; i < 5; i++) do_run(rt[i]);

        // Abort mid-run at idx 500, then a fresh run must complete in full
        fault = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (1000) @(negedge clk);
        o = get_obs(1);
        check("operands at idx500", 64'({o.busy, o.op, o.a, o.b}), 64'({1'b1, 11'h1F4}));
        rst = 1'b1;
        @(negedge clk);
        check("mid-run reset values", 64'(get_obs(1)), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("no done after abort", 64'({busy1, done1}), 64'd0);
        do_run(rt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
